// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
//   Three-master to one-slave Wishbone arbiter. Ownership is granted round
//   robin and held for the whole CYC tenure, so bursts are never split. A
//   stall watchdog aborts slave accesses that go unanswered for TIMEOUT
//   cycles and reports ERR to the owning master.
//
// Parameters
//   TIMEOUT   stalled STB cycles before abort (0 disables), 0..65535
//
// Ports
//   sys_clk, sys_rst          clock, asynchronous active-high reset
//   m_cyc_i/stb_i/we_i [2:0]  per-master bus control
//   m_adr_i/m_dat_i [95:0]    master k in bits [32k+31:32k]
//   m_sel_i [11:0]            master k in bits [4k+3:4k]
//   m_cti_i [8:0]             master k in bits [3k+2:3k]
//   m_dat_o [31:0]            slave read data broadcast to all masters
//   m_ack_o/m_err_o [2:0]     per-master response, only the owner sees it
//   s_* outputs               multiplexed request towards the slave
//   s_dat_i/s_ack_i/s_err_i   slave response
//   grant_o [2:0]             registered one-hot owner, 0 when idle
//   timeout_o                 one-cycle pulse when an access is aborted
module wb_rr_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [2:0]  m_cyc_i,
    input  logic [2:0]  m_stb_i,
    input  logic [2:0]  m_we_i,
    input  logic [95:0] m_adr_i,
    input  logic [95:0] m_dat_i,
    input  logic [11:0] m_sel_i,
    input  logic [8:0]  m_cti_i,
    output logic [31:0] m_dat_o,
    output logic [2:0]  m_ack_o,
    output logic [2:0]  m_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic [2:0]  s_cti_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    output logic [2:0]  grant_o,
    output logic        timeout_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_ABORT = 2'd2;

    localparam bit         WD_EN    = (TIMEOUT != 0);
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

    logic [1:0]  state;
    logic [1:0]  owner;
    logic [1:0]  last;
    logic [15:0] stall_cnt;
    logic [1:0]  pick;
    logic        owner_cyc;
    logic        stall;
    logic [3:0]  cti_base;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Search starts just after the previous owner, so the master that
    // released last is considered last.
    function automatic logic [1:0] rr_pick(input logic [1:0] last_idx,
                                           input logic [2:0] req);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = rr_next(last_idx);
        c2 = rr_next(c1);
        if (req[c1])
            return c1;
        else if (req[c2])
            return c2;
        else
            return last_idx;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

    assign pick      = rr_pick(last, m_cyc_i);
    assign owner_cyc = m_cyc_i[owner];
    assign cti_base  = {1'b0, owner, 1'b0} + {2'b00, owner};
    assign m_dat_o   = s_dat_i;

    // s_stb_o is only non-zero in BUSY, so stall already implies BUSY.
    assign stall = s_stb_o & ~s_ack_i & ~s_err_i;

    // Output mux, combinational from the registered owner
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (state == S_BUSY) begin
            s_cyc_o = m_cyc_i[owner];
            s_stb_o = m_stb_i[owner];
            s_we_o  = m_we_i[owner];
            s_adr_o = m_adr_i[{owner, 5'd0} +: 32];
            s_dat_o = m_dat_i[{owner, 5'd0} +: 32];
            s_sel_o = m_sel_i[{owner, 2'd0} +: 4];
            s_cti_o = m_cti_i[cti_base +: 3];
            m_ack_o = onehot(owner) & {3{s_ack_i}};
            m_err_o = onehot(owner) & {3{s_err_i}};
        end else if (state == S_ABORT && timeout_o) begin
            // timeout_o is high only in the first ABORT cycle, which is
            // exactly when the owner must see its single ERR.
            m_err_o = onehot(owner);
        end
    end

    // Arbitration FSM and stall watchdog
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            owner     <= 2'd0;
            last      <= 2'd2;
            grant_o   <= 3'b000;
            stall_cnt <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    stall_cnt <= '0;
                    if (|m_cyc_i) begin
                        owner   <= pick;
                        grant_o <= onehot(pick);
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!owner_cyc) begin
                        last      <= owner;
                        grant_o   <= 3'b000;
                        stall_cnt <= '0;
                        state     <= S_IDLE;
                    end else if (WD_EN && stall) begin
                        // A response in this cycle clears stall, so ACK/ERR
                        // coinciding with expiry always wins.
                        if (stall_cnt + 16'd1 == WD_LIMIT) begin
                            stall_cnt <= '0;
                            timeout_o <= 1'b1;
                            state     <= S_ABORT;
                        end else begin
                            stall_cnt <= stall_cnt + 16'd1;
                        end
                    end else begin
                        stall_cnt <= '0;
                    end
                end
                S_ABORT: begin
                    stall_cnt <= '0;
                    if (!owner_cyc) begin
                        last    <= owner;
                        grant_o <= 3'b000;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter
//   Directed bench for wb_rr_arbiter (TIMEOUT=8). Inputs change 1 time unit
//   after the rising edge, outputs are sampled 2 units later, so each
//   "cycle n" below is the interval between rising edges n and n+1.
module tb_wb_rr_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [2:0]  m_cyc_i;
    logic [2:0]  m_stb_i;
    logic [2:0]  m_we_i;
    logic [95:0] m_adr_i;
    logic [95:0] m_dat_i;
    logic [11:0] m_sel_i;
    logic [8:0]  m_cti_i;
    logic [31:0] m_dat_o;
    logic [2:0]  m_ack_o;
    logic [2:0]  m_err_o;
    logic        s_cyc_o;
    logic        s_stb_o;
    logic        s_we_o;
    logic [31:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic [3:0]  s_sel_o;
    logic [2:0]  s_cti_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic        s_err_i;
    logic [2:0]  grant_o;
    logic        timeout_o;

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    wb_rr_arbiter #(.TIMEOUT(8)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_sel_i   (m_sel_i),
        .m_cti_i   (m_cti_i),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_cti_o   (s_cti_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_masters();
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = '0;
        m_adr_i = '0;
        m_dat_i = '0;
        m_sel_i = '0;
        m_cti_i = '0;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_dat_i = '0;
    endtask

    // Leaves the arbiter idle with last=2; the caller's cycle 0 starts here.
    task automatic do_reset();
        clear_masters();
        sys_rst = 1'b1;
        next_cycle();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_masters();
        #1 sys_rst = 1'b1;
        #2;
        checks++;
        if (grant_o !== 3'b000) begin
            errors++; $display("FAIL rst_grant: got %b want 000", grant_o);
        end
        checks++;
        if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin
            errors++; $display("FAIL rst_s_ctl: got %b want 000", {s_cyc_o, s_stb_o, s_we_o});
        end
        checks++;
        if ({m_ack_o, m_err_o, timeout_o} !== 7'b0) begin
            errors++; $display("FAIL rst_resp: got %b want 0000000", {m_ack_o, m_err_o, timeout_o});
        end
        // Requests while reset is held must not be granted.
        m_cyc_i = 3'b111;
        m_stb_i = 3'b111;
        next_cycle();
        next_cycle();
        #2;
        checks++;
        if (grant_o !== 3'b000 || s_cyc_o !== 1'b0) begin
            errors++; $display("FAIL rst_held: got grant=%b s_cyc=%b want 000/0", grant_o, s_cyc_o);
        end
        clear_masters();
        sys_rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_read();
        do_reset();
        // cycle 0
        m_cyc_i = 3'b010;
        m_stb_i = 3'b010;
        m_adr_i[63:32] = 32'h6000_0004;
        m_sel_i[7:4] = 4'hF;
        #2;
        checks++;
        if (grant_o !== 3'b000 || s_cyc_o !== 1'b0) begin
            errors++; $display("FAIL rd_c0: got grant=%b s_cyc=%b want 000/0", grant_o, s_cyc_o);
        end
        // cycle 1
        next_cycle();
        #2;
        checks++;
        if (grant_o !== 3'b010 || s_cyc_o !== 1'b1) begin
            errors++; $display("FAIL rd_c1_grant: got grant=%b s_cyc=%b want 010/1", grant_o, s_cyc_o);
        end
        checks++;
        if (s_adr_o !== 32'h6000_0004 || s_we_o !== 1'b0 || s_sel_o !== 4'hF) begin
            errors++; $display("FAIL rd_c1_req: got adr=%h we=%b sel=%h want 60000004/0/f", s_adr_o, s_we_o, s_sel_o);
        end
        checks++;
        if (m_ack_o !== 3'b000) begin
            errors++; $display("FAIL rd_c1_ack: got %b want 000", m_ack_o);
        end
        // cycle 2
        next_cycle();
        #2;
        checks++;
        if (s_cyc_o !== 1'b1) begin
            errors++; $display("FAIL rd_c2_cyc: got %b want 1", s_cyc_o);
        end
        // cycle 3: slave answers
        next_cycle();
        s_ack_i = 1'b1;
        s_dat_i = 32'hDEAD_BEEF;
        #2;
        checks++;
        if (m_ack_o !== 3'b010 || s_cyc_o !== 1'b1) begin
            errors++; $display("FAIL rd_c3_ack: got ack=%b s_cyc=%b want 010/1", m_ack_o, s_cyc_o);
        end
        checks++;
        if (m_dat_o !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rd_c3_dat: got %h want deadbeef", m_dat_o);
        end
        // cycle 4: master ends the tenure
        next_cycle();
        clear_masters();
        #2;
        checks++;
        if (s_cyc_o !== 1'b0 || grant_o !== 3'b010) begin
            errors++; $display("FAIL rd_c4: got s_cyc=%b grant=%b want 0/010", s_cyc_o, grant_o);
        end
        // cycle 5
        next_cycle();
        #2;
        checks++;
        if (grant_o !== 3'b000) begin
            errors++; $display("FAIL rd_c5_grant: got %b want 000", grant_o);
        end
    endtask

    task automatic test_fairness();
        logic [2:0]  exp_g;
        logic [31:0] exp_adr;
        do_reset();
        m_adr_i = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
        for (int k = 0; k < 6; k++) begin
            int e;
            e = k % 3;
            exp_g = 3'b001 << e;
            case (e)
                0:       exp_adr = 32'h1000_0000;
                1:       exp_adr = 32'h2000_0000;
                default: exp_adr = 32'h3000_0000;
            endcase
            // idle cycle: every master requests
            m_cyc_i = 3'b111;
            m_stb_i = 3'b111;
            s_ack_i = 1'b0;
            #2;
            checks++;
            if (grant_o !== 3'b000) begin
                errors++; $display("FAIL fair_idle[%0d]: got %b want 000", k, grant_o);
            end
            // tenure: single beat acked at once
            next_cycle();
            s_ack_i = 1'b1;
            #2;
            checks++;
            if (grant_o !== exp_g || m_ack_o !== exp_g || s_adr_o !== exp_adr) begin
                errors++; $display("FAIL fair_grant[%0d]: got grant=%b ack=%b adr=%h want %b/%b/%h",
                                   k, grant_o, m_ack_o, s_adr_o, exp_g, exp_g, exp_adr);
            end
            // owner drops CYC for one cycle
            next_cycle();
            s_ack_i = 1'b0;
            m_cyc_i[e] = 1'b0;
            m_stb_i[e] = 1'b0;
            #2;
            checks++;
            if (grant_o !== exp_g || s_cyc_o !== 1'b0) begin
                errors++; $display("FAIL fair_drop[%0d]: got grant=%b s_cyc=%b want %b/0", k, grant_o, s_cyc_o, exp_g);
            end
            next_cycle();
        end
        clear_masters();
        next_cycle();
    endtask

    task automatic test_burst();
        logic [31:0] exp_adr;
        logic [2:0]  exp_cti;
        do_reset();
        // cycle 0: master 0 burst and master 2 single both request
        m_cyc_i = 3'b101;
        m_stb_i = 3'b101;
        m_adr_i[31:0]  = 32'h0000_0100;
        m_adr_i[95:64] = 32'h0000_0900;
        m_cti_i[2:0]   = 3'b010;
        #2;
        checks++;
        if (grant_o !== 3'b000) begin
            errors++; $display("FAIL burst_c0: got %b want 000", grant_o);
        end
        next_cycle();
        for (int b = 0; b < 4; b++) begin
            exp_adr = 32'h0000_0100 + 32'(4 * b);
            exp_cti = (b == 3) ? 3'b111 : 3'b010;
            m_adr_i[31:0] = exp_adr;
            m_cti_i[2:0]  = exp_cti;
            s_ack_i = 1'b1;
            #2;
            checks++;
            if (grant_o !== 3'b001 || s_adr_o !== exp_adr || s_cti_o !== exp_cti || m_ack_o !== 3'b001) begin
                errors++; $display("FAIL burst_beat[%0d]: got grant=%b adr=%h cti=%b ack=%b want 001/%h/%b/001",
                                   b, grant_o, s_adr_o, s_cti_o, m_ack_o, exp_adr, exp_cti);
            end
            next_cycle();
        end
        // cycle 5: master 0 releases
        s_ack_i = 1'b0;
        m_cyc_i[0] = 1'b0;
        m_stb_i[0] = 1'b0;
        #2;
        checks++;
        if (grant_o !== 3'b001 || s_cyc_o !== 1'b0) begin
            errors++; $display("FAIL burst_rel: got grant=%b s_cyc=%b want 001/0", grant_o, s_cyc_o);
        end
        next_cycle();
        #2;
        checks++;
        if (grant_o !== 3'b000) begin
            errors++; $display("FAIL burst_gap: got %b want 000", grant_o);
        end
        next_cycle();
        #2;
        checks++;
        if (grant_o !== 3'b100 || s_adr_o !== 32'h0000_0900 || s_cyc_o !== 1'b1) begin
            errors++; $display("FAIL burst_next: got grant=%b adr=%h s_cyc=%b want 100/00000900/1", grant_o, s_adr_o, s_cyc_o);
        end
        clear_masters();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_timeout();
        do_reset();
        // cycle 0
        m_cyc_i = 3'b100;
        m_stb_i = 3'b100;
        next_cycle();
        // cycles 1..8: stalled, master 0 becomes pending in cycle 2
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) begin
                m_cyc_i[0] = 1'b1;
                m_stb_i[0] = 1'b1;
            end
            #2;
            checks++;
            if ({s_cyc_o, m_err_o, timeout_o} !== 5'b1_000_0) begin
                errors++; $display("FAIL to_wait[%0d]: got s_cyc=%b err=%b to=%b want 1/000/0", c, s_cyc_o, m_err_o, timeout_o);
            end
            next_cycle();
        end
        // cycle 9: abort
        #2;
        checks++;
        if (m_err_o !== 3'b100 || timeout_o !== 1'b1) begin
            errors++; $display("FAIL to_abort: got err=%b to=%b want 100/1", m_err_o, timeout_o);
        end
        checks++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || grant_o !== 3'b100) begin
            errors++; $display("FAIL to_abort_bus: got s_cyc=%b s_stb=%b grant=%b want 0/0/100", s_cyc_o, s_stb_o, grant_o);
        end
        // cycle 10: late slave ERR must not be forwarded
        next_cycle();
        s_err_i = 1'b1;
        #2;
        checks++;
        if (m_err_o !== 3'b000 || timeout_o !== 1'b0 || s_cyc_o !== 1'b0) begin
            errors++; $display("FAIL to_after: got err=%b to=%b s_cyc=%b want 000/0/0", m_err_o, timeout_o, s_cyc_o);
        end
        // cycle 11: master 2 gives up
        next_cycle();
        s_err_i = 1'b0;
        m_cyc_i[2] = 1'b0;
        m_stb_i[2] = 1'b0;
        #2;
        checks++;
        if (grant_o !== 3'b100) begin
            errors++; $display("FAIL to_hold: got %b want 100", grant_o);
        end
        next_cycle();
        #2;
        checks++;
        if (grant_o !== 3'b000) begin
            errors++; $display("FAIL to_gap: got %b want 000", grant_o);
        end
        next_cycle();
        #2;
        checks++;
        if (grant_o !== 3'b001 || s_cyc_o !== 1'b1) begin
            errors++; $display("FAIL to_next: got grant=%b s_cyc=%b want 001/1", grant_o, s_cyc_o);
        end
        clear_masters();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_coincident_ack();
        do_reset();
        m_cyc_i = 3'b100;
        m_stb_i = 3'b100;
        // cycles 1..7 stalled
        for (int c = 0; c < 8; c++) next_cycle();
        // cycle 8: ack arrives together with counter expiry
        s_ack_i = 1'b1;
        #2;
        checks++;
        if (m_ack_o !== 3'b100 || m_err_o !== 3'b000 || timeout_o !== 1'b0) begin
            errors++; $display("FAIL co_ack: got ack=%b err=%b to=%b want 100/000/0", m_ack_o, m_err_o, timeout_o);
        end
        next_cycle();
        s_ack_i = 1'b0;
        m_cyc_i = 3'b000;
        m_stb_i = 3'b000;
        #2;
        checks++;
        if (m_err_o !== 3'b000 || timeout_o !== 1'b0 || grant_o !== 3'b100) begin
            errors++; $display("FAIL co_after: got err=%b to=%b grant=%b want 000/0/100", m_err_o, timeout_o, grant_o);
        end
        next_cycle();
        #2;
        checks++;
        if (grant_o !== 3'b000) begin
            errors++; $display("FAIL co_idle: got %b want 000", grant_o);
        end
        next_cycle();
    endtask

    task automatic test_async_reset();
        do_reset();
        m_cyc_i = 3'b001;
        m_stb_i = 3'b001;
        m_cti_i[2:0] = 3'b010;
        next_cycle();
        s_ack_i = 1'b1;
        #2;
        checks++;
        if (grant_o !== 3'b001) begin
            errors++; $display("FAIL ar_pre: got %b want 001", grant_o);
        end
        next_cycle();
        // mid-burst, assert reset between clock edges
        #2;
        sys_rst = 1'b1;
        #1;
        checks++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || grant_o !== 3'b000) begin
            errors++; $display("FAIL ar_drop: got s_cyc=%b s_stb=%b grant=%b want 0/0/000", s_cyc_o, s_stb_o, grant_o);
        end
        checks++;
        if (m_ack_o !== 3'b000) begin
            errors++; $display("FAIL ar_ack: got %b want 000", m_ack_o);
        end
        s_ack_i = 1'b0;
        m_cyc_i = 3'b011;
        m_stb_i = 3'b011;
        next_cycle();
        sys_rst = 1'b0;
        #2;
        checks++;
        if (grant_o !== 3'b000) begin
            errors++; $display("FAIL ar_idle: got %b want 000", grant_o);
        end
        next_cycle();
        #2;
        checks++;
        if (grant_o !== 3'b001 || s_cyc_o !== 1'b1) begin
            errors++; $display("FAIL ar_first: got grant=%b s_cyc=%b want 001/1", grant_o, s_cyc_o);
        end
        clear_masters();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fairness();
        test_burst();
        test_timeout();
        test_coincident_ack();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
